// File: rtl/citrus_hilo_pkg.sv
// Shared definitions for the Citrus HI/LO divide controller.
// The state enum and the divide-by-zero LO value live here.
package citrus_hilo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    FIX
  } hilo_state_e;

  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate of a pair of values.
// Used both to form operand magnitudes and to sign-fix quotient/remainder.
module div_sign_fix
  import citrus_hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg_x,
  input  logic [W-1:0] y,
  input  logic         neg_y,
  output logic [W-1:0] x_fix,
  output logic [W-1:0] y_fix
);

  // Negation wraps mod 2^W, so the most negative value maps onto itself.
  assign x_fix = neg_x ? (-x) : x;
  assign y_fix = neg_y ? (-y) : y;

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner and sequencer for the shared iterative divider.
// Handles signed conversion, divide-by-zero, pipeline stall and flushed divides.
module hilo_div_ctrl
  import citrus_hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         ex_div_valid,
  input  logic         ex_div_signed,
  input  logic [W-1:0] ex_a,
  input  logic [W-1:0] ex_b,
  input  logic         ex_mthi,
  input  logic         ex_mtlo,
  input  logic         ex_mf_req,
  input  logic [W-1:0] ex_wdata,
  input  logic         cancel,
  output logic         stall,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_start,
  input  logic         div_busy,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  hilo_state_e state, state_next;

  logic         killed;
  logic         neg_q, neg_r;
  logic [W-1:0] q_cap, r_cap;
  logic [W-1:0] mag_a, mag_b;
  logic [W-1:0] res_lo, res_hi;
  logic         accept, div0, any_req;
  logic         in_neg_a, in_neg_b;

  assign in_neg_a = ex_div_signed & ex_a[W-1];
  assign in_neg_b = ex_div_signed & ex_b[W-1];
  assign any_req  = ex_div_valid | ex_mthi | ex_mtlo | ex_mf_req;

  div_sign_fix #(.W(W)) u_fix_in (
    .x     (ex_a),
    .neg_x (in_neg_a),
    .y     (ex_b),
    .neg_y (in_neg_b),
    .x_fix (mag_a),
    .y_fix (mag_b)
  );

  div_sign_fix #(.W(W)) u_fix_out (
    .x     (q_cap),
    .neg_x (neg_q),
    .y     (r_cap),
    .neg_y (neg_r),
    .x_fix (res_lo),
    .y_fix (res_hi)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // A flushed divide keeps sequencing so the divider drains, but only blocks
  // the pipeline when something new actually wants HI/LO or the divider.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    stall      = 1'b0;
    accept     = 1'b0;
    div0       = 1'b0;
    case (state)
      IDLE: begin
        if (ex_div_valid) begin
          if (ex_b != '0) begin
            accept     = 1'b1;
            state_next = ISSUE;
          end else begin
            div0 = 1'b1;
          end
        end
      end
      ISSUE: begin
        div_start  = 1'b1;
        state_next = ARM;
      end
      ARM:     if (div_busy)  state_next = WAIT;
      WAIT:    if (!div_busy) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (state != IDLE) begin
      if (killed) stall = any_req;
      else        stall = (state != FIX);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      killed <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div_a  <= '0;
      div_b  <= '0;
      q_cap  <= '0;
      r_cap  <= '0;
    end else begin
      if (accept) begin
        div_a  <= mag_a;
        div_b  <= mag_b;
        neg_q  <= in_neg_a ^ in_neg_b;
        neg_r  <= in_neg_a;
        killed <= 1'b0;
      end else if (cancel && state != IDLE) begin
        killed <= 1'b1;
      end
      if (state == WAIT && !div_busy) begin
        q_cap <= div_q;
        r_cap <= div_r;
      end
    end
  end

  // A cancel arriving in FIX itself still suppresses the write.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (div0) begin
      hi <= ex_a;
      lo <= W'(DIV0_LO);
    end else if (state == FIX) begin
      if (!killed && !cancel) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (state == IDLE) begin
      if (ex_mthi) hi <= ex_wdata;
      if (ex_mtlo) lo <= ex_wdata;
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl with a behavioural divider model,
// directed vectors, randomized divides and cancel/reset corner sequences.
module tb_hilo_div_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ex_div_valid, ex_div_signed;
  logic [31:0] ex_a, ex_b, ex_wdata;
  logic        ex_mthi, ex_mtlo, ex_mf_req, cancel;
  logic        stall, div_start;
  logic [31:0] hi, lo, div_a, div_b;
  logic        div_busy;
  logic [31:0] div_q, div_r;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int armDelay = 0;
  int divLat = 3;

  logic        pending;
  int          cnt;
  logic [31:0] opA, opB;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
    string       name;
  } vec_t;

  vec_t vecs[8];

  hilo_div_ctrl #(.W(32)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .ex_div_valid  (ex_div_valid),
    .ex_div_signed (ex_div_signed),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_mthi       (ex_mthi),
    .ex_mtlo       (ex_mtlo),
    .ex_mf_req     (ex_mf_req),
    .ex_wdata      (ex_wdata),
    .cancel        (cancel),
    .stall         (stall),
    .hi            (hi),
    .lo            (lo),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_start     (div_start),
    .div_busy      (div_busy),
    .div_q         (div_q),
    .div_r         (div_r)
  );

  always #5 clock = ~clock;

  // Divider stand-in: optional delay before busy rises, busy for divLat cycles.
  always @(posedge clock) begin
    if (!resetn) begin
      div_busy <= 1'b0;
      pending  <= 1'b0;
      cnt      <= 0;
      div_q    <= '0;
      div_r    <= '0;
      opA      <= '0;
      opB      <= '0;
    end else if (div_start) begin
      pending <= 1'b1;
      cnt     <= armDelay;
      opA     <= div_a;
      opB     <= div_b;
    end else if (pending) begin
      if (cnt == 0) begin
        pending  <= 1'b0;
        div_busy <= 1'b1;
        cnt      <= divLat;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (div_busy) begin
      if (cnt <= 1) begin
        div_busy <= 1'b0;
        div_q    <= (opB == 0) ? 32'hFFFFFFFF : opA / opB;
        div_r    <= (opB == 0) ? opA : opA % opB;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  always @(negedge clock) if (div_start === 1'b1) startCount++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference: MIPS-style truncating division computed in 64-bit arithmetic.
  function automatic void refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] expLo, output logic [31:0] expHi);
    longint sa, sb, q, r;
    if (b == 0) begin
      expHi = a;
      expLo = 32'hFFFFFFFF;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    expLo = q[31:0];
    expHi = r[31:0];
  endfunction

  function automatic logic [31:0] refMag(input logic sgn, input logic [31:0] v);
    longint s;
    if (!sgn) return v;
    s = longint'($signed(v));
    if (s < 0) s = -s;
    return s[31:0];
  endfunction

  function automatic vec_t mkVec(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expLo, input logic [31:0] expHi, input string name);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.expLo = expLo; v.expHi = expHi; v.name = name;
    return v;
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0:       return 32'h80000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one DIV/DIVU, hold it while stalled, and check the retired result.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expLo, input logic [31:0] expHi, input string name);
    int startsBefore, cyc;
    startsBefore = startCount;
    @(negedge clock);
    ex_div_valid  = 1'b1;
    ex_div_signed = sgn;
    ex_a          = a;
    ex_b          = b;
    if (b == 0) begin
      #1;
      checkOutput({name, " stall"}, 32'(stall), 32'd0);
      @(posedge clock);
      #1;
      ex_div_valid = 1'b0;
    end else begin
      @(negedge clock);
      checkOutput({name, " stall_issue"}, 32'(stall), 32'd1);
      checkOutput({name, " div_a"}, div_a, refMag(sgn, a));
      checkOutput({name, " div_b"}, div_b, refMag(sgn, b));
      cyc = 0;
      while (stall && cyc < 200) begin
        @(negedge clock);
        cyc++;
      end
      if (cyc >= 200) checkOutput({name, " timeout_stall"}, 32'(stall), 32'd0);
      @(posedge clock);
      #1;
      ex_div_valid = 1'b0;
    end
    checkOutput({name, " lo"}, lo, expLo);
    checkOutput({name, " hi"}, hi, expHi);
    checkOutput({name, " starts"}, 32'(startCount - startsBefore), (b == 0) ? 32'd0 : 32'd1);
  endtask

  task automatic moveTo(input logic toHi, input logic [31:0] data);
    @(negedge clock);
    ex_mthi  = toHi;
    ex_mtlo  = ~toHi;
    ex_wdata = data;
    @(posedge clock);
    #1;
    ex_mthi = 1'b0;
    ex_mtlo = 1'b0;
  endtask

  task automatic waitBusy(input string name);
    int cyc;
    cyc = 0;
    while (!div_busy && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 50) checkOutput({name, " timeout_busy"}, 32'(div_busy), 32'd1);
  endtask

  initial begin
    logic [31:0] eLo, eHi, ra, rb;
    logic        rs;
    int          cyc;

    resetn = 1'b0; ex_div_valid = 1'b0; ex_div_signed = 1'b0;
    ex_a = '0; ex_b = '0; ex_wdata = '0;
    ex_mthi = 1'b0; ex_mtlo = 1'b0; ex_mf_req = 1'b0; cancel = 1'b0;

    vecs[0] = mkVec(1'b0, 32'd1000000000, 32'd999999999, 32'd1, 32'd1, "divu_1e9");
    vecs[1] = mkVec(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
    vecs[2] = mkVec(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, "div_min_m1");
    vecs[3] = mkVec(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, "divu_by0");
    vecs[4] = mkVec(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, "div_7_m2");
    vecs[5] = mkVec(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, "div_m100_m7");
    vecs[6] = mkVec(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, "divu_max_2");
    vecs[7] = mkVec(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, "div_by0_neg");

    repeat (2) @(negedge clock);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset div_a", div_a, 32'd0);
    checkOutput("reset div_b", div_b, 32'd0);
    checkOutput("reset div_start", 32'(div_start), 32'd0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      armDelay = i % 3;
      divLat   = 2 + i;
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].expLo, vecs[i].expHi, vecs[i].name);
    end

    for (int i = 0; i < 30; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = pickVal();
      rb = pickVal();
      armDelay = $urandom_range(0, 2);
      divLat   = $urandom_range(1, 8);
      refDiv(rs, ra, rb, eLo, eHi);
      applyStimulus(rs, ra, rb, eLo, eHi, $sformatf("rand%0d", i));
    end

    // Flushed divide must leave the preloaded HI/LO alone.
    moveTo(1'b1, 32'hA);
    moveTo(1'b0, 32'hB);
    checkOutput("mthi hi", hi, 32'hA);
    checkOutput("mtlo lo", lo, 32'hB);
    armDelay = 1;
    divLat   = 6;
    @(negedge clock);
    ex_div_valid = 1'b1; ex_div_signed = 1'b1; ex_a = 32'd100; ex_b = 32'd7;
    @(negedge clock);
    waitBusy("cancel");
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    ex_div_valid = 1'b0;
    ex_mf_req = 1'b1;
    #1;
    checkOutput("cancel mf_stall", 32'(stall), 32'd1);
    cyc = 0;
    while (stall && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("cancel stall_end", 32'(stall), 32'd0);
    checkOutput("cancel mfhi", hi, 32'hA);
    checkOutput("cancel lo", lo, 32'hB);
    ex_mf_req = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("cancel hi_later", hi, 32'hA);
    checkOutput("cancel lo_later", lo, 32'hB);

    // Reset mid-division aborts at once.
    divLat = 10;
    @(negedge clock);
    ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_a = 32'd1000; ex_b = 32'd3;
    @(negedge clock);
    waitBusy("rst");
    resetn = 1'b0;
    ex_div_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    checkOutput("rst stall", 32'(stall), 32'd0);
    checkOutput("rst hi", hi, 32'd0);
    checkOutput("rst lo", lo, 32'd0);
    checkOutput("rst div_a", div_a, 32'd0);
    divLat = 4;
    applyStimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "divu_9_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
